// File: rtl/approx_mul_pkg.sv
// Shared definitions for the approximate multiplier pipeline.
//
// Contents:
//   LAT          fixed pipeline depth of this revision (3 register stages)
//   kw_f()       width of the summed leading-one exponent, $clog2(width)+1
//   pos_w_f()    width of a single leading-one position
//   stage_ctl_t  per-stage control payload that travels alongside the data
//                (valid, result sign, zero-operand flag)
package approx_mul_pkg;

  localparam int LAT = 3;

  // ka + kb reaches 2*(width-1), and stage 3 adds the mantissa carry on top.
  function automatic int kw_f(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic int pos_w_f(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  typedef struct packed {
    logic valid;
    logic sign;
    logic zero;
  } stage_ctl_t;

endpackage

// File: rtl/approx_mul_pipe_leading_one_pos.sv
// leading_one_pos: priority encoder returning the index of the most
// significant set bit of x.
//
// Ports:
//   x     in   WIDTH  value to scan
//   pos   out  PW     index of the highest set bit (0 when x is zero)
//   zero  out  1      x has no bit set
module leading_one_pos
  import approx_mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PW    = pos_w_f(WIDTH)
) (
  input  logic [WIDTH-1:0] x,
  output logic [PW-1:0]    pos,
  output logic             zero
);

  // Scanning upwards lets the highest set bit win.
  always_comb begin
    pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) begin
        pos = PW'(i);
      end
    end
  end

  assign zero = ~|x;

endmodule

// File: rtl/approx_mul_pipe.sv
// approx_mul_pipe: three-stage pipelined Mitchell-style (logarithmic)
// approximate multiplier with valid/ready flow control, per-beat
// signed/unsigned mode and per-beat fraction precision mask.
//
//   stage 1  sign of the result, operand magnitudes, zero flag, mask
//   stage 2  leading-one positions, masked left-aligned fractions,
//            k = ka + kb, s = fa + fb (carry kept)
//   stage 3  mantissa/exponent rebuild, shift, zero force, negate
//
// Ports:
//   clk        in   1         clock, rising edge
//   rst        in   1         asynchronous active-high reset
//   in_valid   in   1         operand beat valid
//   in_ready   out  1         a beat can be accepted this cycle
//   in_a       in   WIDTH     operand A
//   in_b       in   WIDTH     operand B
//   in_signed  in   1         1: two's-complement operands and result
//   in_mask    in   FRAC      fraction mask, bit FRAC-1 weighs 1/2
//   out_valid  out  1         result valid
//   out_ready  in   1         downstream accepts the result
//   out_r      out  2*WIDTH   approximate product (0 whenever out_valid=0)
module approx_mul_pipe #(
  parameter int WIDTH = 8,
  parameter int FRAC  = WIDTH - 1,
  parameter int LAT   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [FRAC-1:0]    in_mask,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_r
);

  import approx_mul_pkg::*;

  localparam int KW = kw_f(WIDTH);
  localparam int PW = pos_w_f(WIDTH);
  localparam int EW = KW + 1;
  localparam int RW = 2 * WIDTH;
  localparam logic [EW-1:0] FRAC_E = EW'(FRAC);

  // Elaboration-time parameter checks.
  if (LAT != approx_mul_pkg::LAT) begin : g_lat_check
    $error("approx_mul_pipe: LAT must be 3 in this revision");
  end
  if (WIDTH < 4) begin : g_width_check
    $error("approx_mul_pipe: WIDTH must be at least 4");
  end
  if ((FRAC < 1) || (FRAC > WIDTH - 1)) begin : g_frac_check
    $error("approx_mul_pipe: FRAC must lie in 1..WIDTH-1");
  end

  // --------------------------------------------------------------------------
  // Flow control. Each stage loads when it is empty or when the stage after
  // it loads in the same cycle, so bubbles collapse and a full pipeline can
  // still accept a beat in the cycle its head drains.
  // --------------------------------------------------------------------------
  stage_ctl_t s1_ctl_reg, s1_ctl_next;
  stage_ctl_t s2_ctl_reg;
  logic       v3_reg;
  logic       ld1, ld2, ld3;

  assign ld3      = ~v3_reg | out_ready;
  assign ld2      = ~s2_ctl_reg.valid | ld3;
  assign ld1      = ~s1_ctl_reg.valid | ld2;
  assign in_ready = ld1;

  // --------------------------------------------------------------------------
  // Stage 1: sign and magnitudes. The most negative operand negates onto
  // itself, which read as unsigned is exactly its magnitude 2^(WIDTH-1).
  // --------------------------------------------------------------------------
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a_next, mag_b_next;

  assign a_neg      = in_signed & in_a[WIDTH-1];
  assign b_neg      = in_signed & in_b[WIDTH-1];
  assign mag_a_next = a_neg ? ((~in_a) + WIDTH'(1)) : in_a;
  assign mag_b_next = b_neg ? ((~in_b) + WIDTH'(1)) : in_b;

  always_comb begin
    s1_ctl_next       = '0;
    s1_ctl_next.valid = in_valid;
    s1_ctl_next.sign  = a_neg ^ b_neg;
    s1_ctl_next.zero  = (mag_a_next == '0) || (mag_b_next == '0);
  end

  logic [WIDTH-1:0] s1_mag_a_reg, s1_mag_b_reg;
  logic [FRAC-1:0]  s1_mask_reg;

  // --------------------------------------------------------------------------
  // Stage 2: leading-one detection and fraction sum.
  // Shifting {mag, FRAC zeros} right by the leading-one position puts the
  // leading one at bit FRAC; the cast keeps only the bits below it, already
  // left-aligned. Fraction bits finer than FRAC fall off the bottom.
  // --------------------------------------------------------------------------
  logic [PW-1:0]   ka, kb;
  logic            za, zb;
  logic [FRAC-1:0] fa, fb;
  logic [KW-1:0]   k_next;
  logic [FRAC:0]   s_next;

  leading_one_pos #(.WIDTH(WIDTH), .PW(PW)) u_lop_a (
    .x    (s1_mag_a_reg),
    .pos  (ka),
    .zero (za)
  );

  leading_one_pos #(.WIDTH(WIDTH), .PW(PW)) u_lop_b (
    .x    (s1_mag_b_reg),
    .pos  (kb),
    .zero (zb)
  );

  assign fa     = FRAC'({s1_mag_a_reg, {FRAC{1'b0}}} >> ka) & s1_mask_reg;
  assign fb     = FRAC'({s1_mag_b_reg, {FRAC{1'b0}}} >> kb) & s1_mask_reg;
  assign k_next = KW'(ka) + KW'(kb);
  assign s_next = {1'b0, fa} + {1'b0, fb};

  logic [KW-1:0] s2_k_reg;
  logic [FRAC:0] s2_s_reg;

  // --------------------------------------------------------------------------
  // Stage 3: rebuild 1.f and shift. A fraction carry means fa+fb >= 1; the
  // product is then taken as 2^(k+1)*(fa+fb), whose mantissa is the same
  // {1, s[FRAC-1:0]} pattern one octave higher. The shift by exp-FRAC is
  // split by direction so the dropped low bits are simply truncated.
  // --------------------------------------------------------------------------
  logic [EW-1:0] exp3;
  logic [FRAC:0] m3;
  logic [RW-1:0] mag3;
  logic [RW-1:0] r3_next;

  always_comb begin
    exp3 = EW'(s2_k_reg) + EW'(s2_s_reg[FRAC]);
    m3   = {1'b1, s2_s_reg[FRAC-1:0]};
    if (exp3 >= FRAC_E) begin
      mag3 = RW'(m3) << (exp3 - FRAC_E);
    end else begin
      mag3 = RW'(m3) >> (FRAC_E - exp3);
    end
    if (s2_ctl_reg.zero) begin
      mag3 = '0;
    end
    r3_next = s2_ctl_reg.sign ? ((~mag3) + RW'(1)) : mag3;
  end

  logic [RW-1:0] r3_reg;

  // --------------------------------------------------------------------------
  // Registers. Control/valid state is reset; datapath registers are not and
  // only load when a real beat moves into them.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_ctl_reg <= '0;
      s2_ctl_reg <= '0;
      v3_reg     <= 1'b0;
    end else begin
      if (ld1) s1_ctl_reg <= s1_ctl_next;
      if (ld2) s2_ctl_reg <= s1_ctl_reg;
      if (ld3) v3_reg     <= s2_ctl_reg.valid;
    end
  end

  always_ff @(posedge clk) begin
    if (ld1 && in_valid) begin
      s1_mag_a_reg <= mag_a_next;
      s1_mag_b_reg <= mag_b_next;
      s1_mask_reg  <= in_mask;
    end
    if (ld2 && s1_ctl_reg.valid) begin
      s2_k_reg <= k_next;
      s2_s_reg <= s_next;
    end
    if (ld3 && s2_ctl_reg.valid) begin
      r3_reg <= r3_next;
    end
  end

  // The stage-1 zero flag and the encoders' zero outputs describe the same
  // operands and must agree for every live beat.
  always_ff @(posedge clk) begin
    if (!rst && s1_ctl_reg.valid) begin
      assert ((za | zb) == s1_ctl_reg.zero);
    end
  end

  // Gating with the valid bit makes out_r read 0 immediately when rst
  // asserts, without having to reset the wide result register.
  assign out_valid = v3_reg;
  assign out_r     = r3_reg & {RW{v3_reg}};

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Testbench for approx_mul_pipe (WIDTH=8): directed vectors, backpressure,
// mid-stream reset and randomized traffic checked through a scoreboard.
package tb_approx_mul_pkg;

  function automatic int msb_pos(input longint unsigned x);
    int p = 0;
    while ((x >> (p + 1)) != 0) p++;
    return p;
  endfunction

  // Mitchell approximation from the arithmetic definition: each operand is
  // 2^k * (1 + f) with f truncated to frac bits and masked; the product is
  // 2^(ka+kb) * (1 + fa + fb) when fa+fb < 1 and 2^(ka+kb+1) * (fa + fb)
  // otherwise, truncated to an integer.
  function automatic longint unsigned approx_mul_model(
    input int              width,
    input int              frac,
    input longint unsigned a,
    input longint unsigned b,
    input bit              sgn,
    input longint unsigned mask
  );
    longint unsigned half, full, ma, mb, one, fa, fb, s, mag, rmod;
    bit na, nb;
    int ka, kb, k;
    half = 64'd1 << (width - 1);
    full = 64'd1 << width;
    rmod = 64'd1 << (2 * width);
    na   = sgn && ((a & half) != 0);
    nb   = sgn && ((b & half) != 0);
    ma   = na ? (full - a) : a;
    mb   = nb ? (full - b) : b;
    if (ma == 0 || mb == 0) return 64'd0;
    ka  = msb_pos(ma);
    kb  = msb_pos(mb);
    one = 64'd1 << frac;
    fa  = (((ma - (64'd1 << ka)) * one) >> ka) & mask;
    fb  = (((mb - (64'd1 << kb)) * one) >> kb) & mask;
    s   = fa + fb;
    k   = ka + kb;
    if (s < one) mag = ((one + s) << k) >> frac;
    else         mag = (s << (k + 1)) >> frac;
    if (na ^ nb) mag = (rmod - mag) & (rmod - 1);
    return mag;
  endfunction

endpackage

module tb_approx_mul_pipe;
  import tb_approx_mul_pkg::*;

  localparam int WIDTH = 8;
  localparam int FRAC  = WIDTH - 1;
  localparam int RW    = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_signed = 1'b0;
  logic [FRAC-1:0]  in_mask = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [RW-1:0]    out_r;

  always #5 clk = ~clk;

  approx_mul_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .LAT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [RW-1:0] exp_q[$];
  int            acc_q[$];
  bit            chk_lat  = 1'b0;
  int            rdy_mode = 0;   // 0: ready, 1: random, 2: stalled
  bit            held_vld = 1'b0;
  logic [RW-1:0] held_r;
  logic [RW-1:0] mon_want;
  int            mon_acc;
  int            beat_no = 0;

  task automatic check(input string name, input longint unsigned got,
                       input longint unsigned want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  // Downstream ready generator.
  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom % 4) != 0;
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every output transfer and checks that a
  // stalled output holds its value.
  always @(negedge clk) begin
    if (rst) begin
      held_vld = 1'b0;
    end else begin
      if (held_vld) begin
        check("hold_valid", out_valid, 1);
        check("hold_r", out_r, held_r);
        held_vld = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_output: got out_r 0x%04h, want no output", out_r);
        end else begin
          mon_want = exp_q.pop_front();
          mon_acc  = acc_q.pop_front();
          $display("beat %0d: out_r=0x%04h expected=0x%04h latency=%0d",
                   beat_no, out_r, mon_want, cyc - mon_acc);
          beat_no++;
          check("result", out_r, mon_want);
          if (chk_lat) check("latency", cyc - mon_acc, 3);
        end
      end else if (out_valid) begin
        held_vld = 1'b1;
        held_r   = out_r;
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic s, input logic [FRAC-1:0] m,
                      input logic [RW-1:0] want);
    int waited = 0;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_mask   = m;
    in_valid  = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(want);
        acc_q.push_back(cyc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      waited++;
      if (waited > 1000) begin
        n_vec++;
        n_err++;
        $display("FAIL accept_timeout: in_ready low for %0d cycles, want 1", waited);
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic send_rand();
    logic [WIDTH-1:0] a, b;
    logic             s;
    logic [FRAC-1:0]  m;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    s = 1'($urandom);
    m = FRAC'($urandom);
    send(a, b, s, m, RW'(approx_mul_model(WIDTH, FRAC, a, b, s, m)));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [6:0]  m;
    logic [15:0] r;
  } vec_t;

  vec_t dir_tab [10] = '{
    '{8'd3,   8'd5,   1'b0, 7'h7F, 16'd14},
    '{8'd6,   8'd6,   1'b0, 7'h7F, 16'd32},
    '{8'd128, 8'd128, 1'b0, 7'h7F, 16'd16384},
    '{8'hFD,  8'h05,  1'b1, 7'h7F, 16'hFFF2},
    '{8'h80,  8'h80,  1'b1, 7'h7F, 16'd16384},
    '{8'h00,  8'hF9,  1'b1, 7'h7F, 16'h0000},
    '{8'd3,   8'd5,   1'b0, 7'h00, 16'd8},
    '{8'd3,   8'd7,   1'b0, 7'h40, 16'd16},
    '{8'hFF,  8'hFF,  1'b0, 7'h7F, 16'd65024},
    '{8'hFF,  8'hFF,  1'b1, 7'h7F, 16'd1}
  };

  initial begin
    bit stale;
    int w;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_r", out_r, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors, back to back, latency checked.
    chk_lat = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(dir_tab[i].a, dir_tab[i].b, dir_tab[i].s, dir_tab[i].m, dir_tab[i].r);
    end
    idle(6);
    chk_lat = 1'b0;
    check("directed_drained", exp_q.size(), 0);

    // Backpressure: downstream stalls while 8 beats stream in.
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
      end
      begin
        repeat (4) @(posedge clk);
        rdy_mode = 2;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_in_flight", exp_q.size(), 3);
        rdy_mode = 0;
      end
    join
    idle(8);
    check("bp_drained", exp_q.size(), 0);

    // Reset with two beats in flight and the output stalled.
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send_rand();
    send_rand();
    repeat (2) @(posedge clk);
    #3;
    check("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_async_out_valid", out_valid, 0);
    check("rst_async_out_r", out_r, 0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    rdy_mode = 0;
    stale    = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("no_stale_after_rst", stale, 0);
    @(posedge clk);
    #1;

    // Random traffic with random gaps, mode, mask and downstream ready.
    rdy_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 5 == 0) idle($urandom_range(1, 3));
      send_rand();
    end
    rdy_mode = 0;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("final_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
